// File: rtl/mc_ctrl_pkg.sv
// mc_controller shared definitions: opcodes, funct codes, FSM states,
// datapath select encodings and ALU-decode helpers.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [9:0] FF_ADD  = 10'b0000000_000;
  localparam logic [9:0] FF_SUB  = 10'b0100000_000;
  localparam logic [9:0] FF_SLL  = 10'b0000000_001;
  localparam logic [9:0] FF_SLT  = 10'b0000000_010;
  localparam logic [9:0] FF_SLTU = 10'b0000000_011;
  localparam logic [9:0] FF_XOR  = 10'b0000000_100;
  localparam logic [9:0] FF_SRL  = 10'b0000000_101;
  localparam logic [9:0] FF_SRA  = 10'b0100000_101;
  localparam logic [9:0] FF_OR   = 10'b0000000_110;
  localparam logic [9:0] FF_AND  = 10'b0000000_111;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_FAULT  = 4'd5
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP = 4'd6
`endif
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [2:0] IMM_SEX12 = 3'd0;
  localparam logic [2:0] IMM_UEX12 = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_J     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;

  localparam logic [2:0] RM_LB  = 3'b110;
  localparam logic [2:0] RM_LH  = 3'b011;
  localparam logic [2:0] RM_LW  = 3'b000;
  localparam logic [2:0] RM_LBU = 3'b010;
  localparam logic [2:0] RM_LHU = 3'b001;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SB   = 2'b11;

  // ALUSrc: bit0 selects immediate for B, bit1 selects PC for A
  localparam logic [1:0] SRC_REG    = 2'b00;
  localparam logic [1:0] SRC_IMM    = 2'b01;
  localparam logic [1:0] SRC_PC_IMM = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  function automatic logic ff_legal(logic [9:0] ff, logic is_imm);
    logic [6:0] f7;
    f7 = ff[9:3];
    if (is_imm) begin
      if (ff[2:0] == F3_SLL) return f7 == 7'd0;
      if (ff[2:0] == F3_SR) return f7 == 7'd0 || f7 == 7'b0100000;
      return 1'b1;
    end
    return f7 == 7'd0 || ff == FF_SUB || ff == FF_SRA;
  endfunction

  // Immediate forms ignore funct7 except for the right shifts
  function automatic logic [3:0] alu_op(logic [9:0] ff, logic is_imm);
    logic [9:0] k;
    k = (is_imm && ff[2:0] != F3_SR) ? {7'd0, ff[2:0]} : ff;
    case (k)
      FF_SUB:  return ALU_SUB;
      FF_SLL:  return ALU_SLL;
      FF_SLT:  return ALU_SLT;
      FF_SLTU: return ALU_SLTU;
      FF_XOR:  return ALU_XOR;
      FF_SRL:  return ALU_SRL;
      FF_SRA:  return ALU_SRA;
      FF_OR:   return ALU_OR;
      FF_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_branch_cmp.sv
// Branch condition evaluator for the multi-cycle controller.
// Purely combinational; unused funct3 codes are never taken.
module branch_cmp
  import mc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_funct3,
  output logic            o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_a == i_b;
      F3_BNE:  o_taken = i_a != i_b;
      F3_BLT:  o_taken = $signed(i_a) < $signed(i_b);
      F3_BGE:  o_taken = $signed(i_a) >= $signed(i_b);
      F3_BLTU: o_taken = i_a < i_b;
      F3_BGEU: o_taken = i_a >= i_b;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// RV32I multi-cycle controller over one shared req/ready memory port.
// Optional ILLEGAL_TRAP_EN stops the FSM in TRAP on illegal encodings.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] RF_OUT1,
  input  logic [XLEN-1:0] RF_OUT2,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            RegWrite,
  output logic [1:0]      PCSrc,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      MemWrite,
  output logic [2:0]      READMODE,
  output logic [2:0]      ImmSrc,
  output logic [1:0]      ALUSrc,
  output logic [3:0]      ALUControl,
  output logic            bus_error,
  output logic            trap,
  output logic [3:0]      state
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 :
                      $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_wd;
  logic [CW:0]   w_wd_inc;
  logic          w_req, w_wd_fire, w_taken, w_dec_on;
  logic          w_rr, w_ri, w_lui, w_auipc, w_jal;
  logic          w_jalr, w_br, w_ld, w_st, w_illegal;
  logic [2:0]    w_f3, w_imm, w_rm;
  logic [9:0]    w_ff;
  logic [1:0]    w_asrc, w_mw;
  logic [3:0]    w_alu;
  logic          w_unused;

  assign w_f3     = Instr[14:12];
  assign w_ff     = {Instr[31:25], w_f3};
  assign w_unused = ^{Instr[24:15], Instr[11:7]};

  assign w_rr    = Instr[6:0] == OP_REG;
  assign w_ri    = Instr[6:0] == OP_IMM;
  assign w_lui   = Instr[6:0] == OP_LUI;
  assign w_auipc = Instr[6:0] == OP_AUIPC;
  assign w_jal   = Instr[6:0] == OP_JAL;
  assign w_jalr  = Instr[6:0] == OP_JALR;
  assign w_br    = Instr[6:0] == OP_BR;
  assign w_ld    = Instr[6:0] == OP_LOAD;
  assign w_st    = Instr[6:0] == OP_STORE;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_a      (RF_OUT1),
    .i_b      (RF_OUT2),
    .i_funct3 (w_f3),
    .o_taken  (w_taken)
  );

  always_comb begin
    w_imm     = IMM_SEX12;
    w_asrc    = SRC_REG;
    w_alu     = ALU_ADD;
    w_rm      = RM_LW;
    w_mw      = MW_NONE;
    w_illegal = 1'b0;
    unique case (1'b1)
      w_rr: begin
        w_alu     = alu_op(w_ff, 1'b0);
        w_illegal = !ff_legal(w_ff, 1'b0);
      end
      w_ri: begin
        w_asrc    = SRC_IMM;
        w_imm     = (w_f3 == F3_SLTU) ? IMM_UEX12 : IMM_SEX12;
        w_alu     = alu_op(w_ff, 1'b1);
        w_illegal = !ff_legal(w_ff, 1'b1);
      end
      w_lui: begin
        w_imm  = IMM_U;
        w_asrc = SRC_IMM;
        w_alu  = ALU_PASSB;
      end
      w_auipc: begin
        w_imm  = IMM_U;
        w_asrc = SRC_PC_IMM;
      end
      w_jal: begin
        w_imm  = IMM_J;
        w_asrc = SRC_PC_IMM;
      end
      w_br: begin
        w_imm  = IMM_B;
        w_asrc = SRC_PC_IMM;
      end
      w_jalr, w_st: w_asrc = SRC_IMM;
      w_ld: begin
        w_asrc = SRC_IMM;
        case (w_f3)
          F3_LB:   w_rm = RM_LB;
          F3_LH:   w_rm = RM_LH;
          F3_LBU:  w_rm = RM_LBU;
          F3_LHU:  w_rm = RM_LHU;
          default: w_rm = RM_LW;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_st) begin
      case (w_f3)
        F3_SB:   w_mw = MW_SB;
        F3_SH:   w_mw = MW_SH;
        F3_SW:   w_mw = MW_SW;
        default: w_mw = MW_NONE;
      endcase
    end
  end

  // Watchdog: stalled request cycles within one state
  assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wd_inc  = {1'b0, r_wd} + (CW+1)'(1);
  assign w_wd_fire = (TIMEOUT_CYCLES != 0) && w_req && !mem_ready &&
                     (w_wd_inc == (CW+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset || w_next != r_state) r_wd <= '0;
    else if (w_req && !mem_ready)   r_wd <= w_wd_inc[CW-1:0];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_wd_fire) w_next = S_FAULT;
      end
      S_DECODE: begin
        w_next = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (w_illegal) w_next = S_TRAP;
`endif
      end
      S_EXEC: w_next = (w_ld || w_st) ? S_MEM : S_FETCH;
      S_MEM: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_wd_fire) w_next = S_FAULT;
      end
      default: w_next = r_state;
    endcase
  end

  assign w_dec_on = !w_illegal && (r_state == S_DECODE ||
                    r_state == S_EXEC || r_state == S_MEM);
  assign ImmSrc     = w_dec_on ? w_imm  : 3'd0;
  assign ALUSrc     = w_dec_on ? w_asrc : 2'd0;
  assign ALUControl = w_dec_on ? w_alu  : 4'd0;
  assign READMODE   = w_dec_on ? w_rm   : 3'd0;
  assign MemWrite   = (r_state == S_MEM) ? w_mw : MW_NONE;
  assign state      = r_state;

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    PCSrc     = PC_PLUS4;
    ResultSrc = RES_ALU;
    bus_error = 1'b0;
    trap      = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
      end
      S_EXEC: begin
        if (w_illegal) PCWrite = 1'b1;
        else begin
          unique case (1'b1)
            w_rr, w_ri, w_lui, w_auipc: begin
              RegWrite = 1'b1;
              PCWrite  = 1'b1;
            end
            w_br: begin
              PCWrite = 1'b1;
              PCSrc   = w_taken ? PC_TARGET : PC_PLUS4;
            end
            w_jal, w_jalr: begin
              RegWrite  = 1'b1;
              ResultSrc = RES_PC4;
              PCWrite   = 1'b1;
              PCSrc     = w_jal ? PC_TARGET : PC_JALR;
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          PCWrite = 1'b1;
          if (w_ld) begin
            RegWrite  = 1'b1;
            ResultSrc = RES_MEM;
          end
        end
      end
      S_FAULT: bus_error = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle controller: a registered FSM that sequences FETCH/DECODE/EXECUTE/MEMORY for RV32I over a single shared memory port with a req/ready handshake, so instruction and data memory (and the UART peripheral) may insert wait states. It drives the datapath enables (PC, IR, register file, memory), mux selects and ALU control. Datapath width is parametrised, and a watchdog flags a hung bus.

## Interface
- XLEN, 32, width of RF_OUT1/RF_OUT2 used by the branch comparator.
- TIMEOUT_CYCLES, 255, number of mem_req cycles without mem_ready that raises bus_error; 0 disables the watchdog.
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction register output, stable from DECODE onward.
- RF_OUT1, RF_OUT2  in  XLEN  register file read data.
- mem_ready  in  1  memory completes the current transfer this cycle.
- mem_req  out  1  memory transfer request.
- AdrSrc  out  1  0 = PC, 1 = ALU result.
- IRWrite, PCWrite, RegWrite  out  1 each  register enables.
- PCSrc  out  2  0 = PC+4, 1 = ALU target (branch/JAL), 2 = ALU result & ~1 (JALR).
- ResultSrc  out  2  0 = ALU, 1 = memory read data, 2 = PC+4.
- MemWrite  out  2  00 = none/read, 01 = SW, 10 = SH, 11 = SB.
- READMODE  out  3  110 = LB, 011 = LH, 000 = LW, 010 = LBU, 001 = LHU.
- ImmSrc  out  3  000 = SEX12, 001 = UEX12 (SLTIU), 010 = B, 011 = J, 100 = U.
- ALUSrc  out  2; ALUControl  out  4  same encodings as the single-cycle controller.
- bus_error  out  1  sticky watchdog fault.
- trap  out  1  sticky illegal-instruction fault (see Configuration).
- state  out  4  current FSM state, debug.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, FAULT (plus TRAP when configured).
- RST: entered on reset. All outputs are 0. Moves to FETCH on the next cycle.
- FETCH: mem_req=1, AdrSrc=0, MemWrite=00. When mem_ready=1, asserts IRWrite=1 the same cycle and moves to DECODE.
- DECODE: one cycle. No enables asserted. The register file reads rs1/rs2.
- EXEC (one cycle, then FETCH unless noted):
  - REG_REG, REG_IMM, LUI, AUIPC: RegWrite=1, ResultSrc=0, PCWrite=1, PCSrc=0.
  - BRANCH: PCWrite=1. PCSrc=1 if the comparison is taken, else 0. Comparisons: EQ, NE, signed LT/GE, unsigned LTU/GEU. An unused funct3 is not taken.
  - JAL: RegWrite=1, ResultSrc=2, PCWrite=1, PCSrc=1.
  - JALR: RegWrite=1, ResultSrc=2, PCWrite=1, PCSrc=2.
  - LOAD, STORE: compute the address and go to MEM. No enables asserted.
- MEM: mem_req=1, AdrSrc=1, MemWrite/READMODE decoded from funct3. On mem_ready:
  - load: RegWrite=1, ResultSrc=1.
  - store: no register write.
  - both: PCWrite=1, PCSrc=0, then FETCH.
- Decode outputs (ImmSrc, ALUSrc, ALUControl, READMODE) are combinational from Instr and are qualified by state. Outside DECODE/EXEC/MEM they are 0.
- Handshake rules:
  - Once raised, mem_req and the address select stay constant until the cycle mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - One transfer per request. mem_req may stay high back-to-back only across different states.
- Watchdog:
  - The counter clears on every state change and counts cycles with mem_req=1 and mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, the FSM enters FAULT. In FAULT, bus_error=1, all enables are 0 and mem_req=0. It holds until reset.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Reset mid-transfer: the state returns to RST at the edge and mem_req=0 the next cycle. Memory must abandon the transfer. A concurrent mem_ready is ignored.

## Timing
- Zero-wait memory means mem_ready is high in the first req cycle.
- ALU, branch and jump instructions: 3 cycles (FETCH, DECODE, EXEC).
- Load and store instructions: 4 cycles. Each wait cycle adds 1.
- All enables are Moore/Mealy on the current state and mem_ready. No registered-output delay.
- Leaving reset: first mem_req in the 2nd cycle after reset deasserts.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An opcode outside the nine RV32I classes, or an undefined funct7/funct3 on REG_REG/shift, moves DECODE to TRAP.
  - In TRAP, trap=1 and all enables are 0. It holds until reset.
- Undefined: such instructions execute as NOP (EXEC with only PCWrite=1, PCSrc=0), and trap is tied 0.

## Structure
- Package mc_ctrl_pkg holds:
  - the opcode, funct3 and {funct7,funct3} constants;
  - the state enum;
  - the PCSrc, ResultSrc, ImmSrc, READMODE and MemWrite code constants.
- Sub-module branch_cmp: combinational, XLEN-parametrised. Inputs: a, b, funct3. Output: taken.

## Test plan
- ADDI x1,x0,5 with zero-wait memory -> IRWrite in cycle 1, RegWrite with ResultSrc=0 in cycle 3, PCWrite with PCSrc=0 in cycle 3, back in FETCH in cycle 4.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req and AdrSrc=1 held 4 cycles, RegWrite=1, ResultSrc=1, READMODE=000 only on the ready cycle.
- BLT with RF_OUT1=0xFFFFFFFF, RF_OUT2=1 -> PCSrc=1. BLTU with the same operands -> PCSrc=0.
- SB -> MemWrite=11 only in MEM. JALR -> RegWrite=1, ResultSrc=2, PCSrc=2.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=8 -> FAULT after 8 cycles, bus_error=1, mem_req=0, held until reset.
- Opcode 0x7F -> with ILLEGAL_TRAP_EN, trap=1 and the FSM stops. Without it, PC+4 only. Reset asserted during MEM wait -> state RST, all outputs 0.
